// File: rtl/savestate_sequencer.sv
// Savestate bus sequencer (clk_sys): walks the 116-word savestate image between the
// core's savestate bus and the bridge FIFOs, and drives the APF create/load status flags.
module savestate_sequencer #(
   parameter int WORD_COUNT    = 116,
   parameter int READY_TIMEOUT = 65535,
   parameter int ACK_CYCLES    = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_savestate_create,
   input  logic       start_savestate_load,
   input  logic       data_ready_savestate_load,
   input  logic       data_consumed_savestate_create,
   output logic       req_read_savestate_load,
   output logic       req_write_savestate_create,
   output logic       savestate_load_ack,
   output logic       savestate_load_busy,
   output logic       savestate_load_ok,
   output logic       savestate_load_err,
   output logic       savestate_create_ack,
   output logic       savestate_create_busy,
   output logic       savestate_create_ok,
   output logic       savestate_create_err,
   output logic [7:0] bus_addr,
   output logic       bus_wren,
   output logic       bus_reset,
   input  logic       ss_ready,
   output logic       ss_halt,
   output logic       ss_begin_reset,
   output logic       ss_turbo
);
   localparam logic [7:0]       LAST_ADDR = 8'(WORD_COUNT - 1);
   localparam logic [15:0]      TMO_MAX   = 16'(READY_TIMEOUT);
   localparam int               ACK_W     = $clog2(ACK_CYCLES + 1);
   localparam logic [ACK_W-1:0] ACK_LOAD  = ACK_W'(ACK_CYCLES);

   typedef enum logic [3:0] {
      IDLE, C_HALT, C_ADDR, C_PUSH, L_RESET, L_HALT, L_POP, L_WRITE, DONE
   } state_t;

   state_t           r_state, w_next;
   logic             r_create_d, r_load_d;
   logic             w_create_edge, w_load_edge, w_accept_c, w_accept_l;
   logic             w_tmo_hit, w_last;
   logic [15:0]      r_tmo;
   logic [ACK_W-1:0] r_cack_cnt, r_lack_cnt;
   logic [7:0]       r_addr;
   logic             r_c_ok, r_c_err, r_l_ok, r_l_err;

   assign w_create_edge = start_savestate_create & ~r_create_d;
   assign w_load_edge   = start_savestate_load & ~r_load_d;
   // Create wins a tie; the load edge is dropped, not deferred.
   assign w_accept_c    = (r_state == IDLE) & w_create_edge;
   assign w_accept_l    = (r_state == IDLE) & w_load_edge & ~w_create_edge;
   assign w_tmo_hit     = (r_tmo == TMO_MAX);
   assign w_last        = (r_addr == LAST_ADDR);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_accept_c)      w_next = C_HALT;
            else if (w_accept_l) w_next = L_RESET;
         end
         C_HALT: begin
            if (ss_ready)       w_next = C_ADDR;
            else if (w_tmo_hit) w_next = DONE;
         end
         C_ADDR:  w_next = C_PUSH;
         C_PUSH: begin
            if (data_consumed_savestate_create) w_next = w_last ? DONE : C_ADDR;
         end
         L_RESET: w_next = L_HALT;
         L_HALT: begin
            if (ss_ready)       w_next = L_POP;
            else if (w_tmo_hit) w_next = DONE;
         end
         L_POP: begin
            if (data_ready_savestate_load) w_next = L_WRITE;
         end
         L_WRITE: w_next = w_last ? DONE : L_POP;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_create_d <= 1'b0;
         r_load_d   <= 1'b0;
         r_tmo      <= '0;
         r_cack_cnt <= '0;
         r_lack_cnt <= '0;
         r_addr     <= '0;
         r_c_ok     <= 1'b0;
         r_c_err    <= 1'b0;
         r_l_ok     <= 1'b0;
         r_l_err    <= 1'b0;
      end else begin
         r_create_d <= start_savestate_create;
         r_load_d   <= start_savestate_load;

         if (w_accept_c)            r_cack_cnt <= ACK_LOAD;
         else if (r_cack_cnt != '0) r_cack_cnt <= r_cack_cnt - 1'b1;
         if (w_accept_l)            r_lack_cnt <= ACK_LOAD;
         else if (r_lack_cnt != '0) r_lack_cnt <= r_lack_cnt - 1'b1;

         // Counter is zero on entry to either halt wait, then saturates.
         if (r_state != C_HALT && r_state != L_HALT) r_tmo <= '0;
         else if (!w_tmo_hit)                        r_tmo <= r_tmo + 1'b1;

         if (w_accept_c || w_accept_l) begin
            r_c_ok  <= 1'b0;
            r_c_err <= 1'b0;
            r_l_ok  <= 1'b0;
            r_l_err <= 1'b0;
         end

         unique case (r_state)
            C_HALT: begin
               if (ss_ready)       r_addr  <= '0;
               else if (w_tmo_hit) r_c_err <= 1'b1;
            end
            C_PUSH: begin
               if (data_consumed_savestate_create) begin
                  if (w_last) r_c_ok  <= 1'b1;
                  else        r_addr  <= r_addr + 1'b1;
               end
            end
            L_HALT: begin
               if (ss_ready)       r_addr  <= '0;
               else if (w_tmo_hit) r_l_err <= 1'b1;
            end
            L_WRITE: begin
               if (w_last) r_l_ok <= 1'b1;
               else        r_addr <= r_addr + 1'b1;
            end
            DONE:    r_addr <= '0;
            default: ;
         endcase
      end
   end

   assign req_read_savestate_load    = (r_state == L_POP) & data_ready_savestate_load;
   assign req_write_savestate_create = (r_state == C_PUSH) & data_consumed_savestate_create;
   assign bus_wren                   = (r_state == L_WRITE);
   assign bus_reset                  = (r_state == L_RESET);
   assign ss_begin_reset             = (r_state == L_RESET);
   assign bus_addr                   = r_addr;

   assign savestate_create_busy = (r_state == C_HALT) | (r_state == C_ADDR) | (r_state == C_PUSH);
   assign savestate_load_busy   = (r_state == L_RESET) | (r_state == L_HALT) |
                                  (r_state == L_POP) | (r_state == L_WRITE);
   assign ss_halt               = savestate_create_busy | savestate_load_busy;
   assign ss_turbo              = savestate_load_busy;

   assign savestate_create_ack = (r_cack_cnt != '0);
   assign savestate_load_ack   = (r_lack_cnt != '0);
   assign savestate_create_ok  = r_c_ok;
   assign savestate_create_err = r_c_err;
   assign savestate_load_ok    = r_l_ok;
   assign savestate_load_err   = r_l_err;
endmodule
